// File: rtl/pll_lock_rst_ctrl.sv
// PLL lock qualification and reset sequencer for the 80 MHz domain.
// Runs from the free-running 25 MHz reference; retries the PLL on lock timeout.
module pll_lock_rst_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int PLL_RST_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             clear_counts,
    output logic             pll_rst,
    output logic             clk_en,
    output logic             sys_rst_n,
    output logic [CNT_W-1:0] lock_lost_count,
    output logic [CNT_W-1:0] retry_count,
    output logic [2:0]       state_o
);

    localparam int MAX_AB  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CD  = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    localparam logic [CYC_W-1:0] PR_LAST = CYC_W'(PLL_RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] ST_LAST = CYC_W'(STABLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] HD_LAST = CYC_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_HOLD   = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CYC_W-1:0]       cyc_q, cyc_d;
    logic                   locked_s;
    logic                   lost_inc, retry_inc;

    assign locked_s = sync_q[SYNC_STAGES-1];
    assign state_o  = state_q;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic clr);
        if (clr)
            return inc ? CNT_W'(1) : '0;
        if (inc && (cur != '1))
            return cur + 1'b1;
        return cur;
    endfunction

    always_comb begin
        state_d   = state_q;
        lost_inc  = 1'b0;
        retry_inc = 1'b0;
        case (state_q)
            S_PLLRST: if (cyc_q == PR_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cyc_q == TO_LAST) begin
                    state_d   = S_PLLRST;
                    retry_inc = 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s)             state_d = S_WAIT;
                else if (cyc_q == ST_LAST) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!locked_s)             state_d = S_WAIT;
                else if (cyc_q == HD_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d  = S_WAIT;
                    lost_inc = 1'b1;
                end
            end
            default: state_d = S_PLLRST;
        endcase
        cyc_d = (state_d != state_q) ? '0 : cyc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_PLLRST;
            sync_q          <= '0;
            cyc_q           <= '0;
            pll_rst         <= 1'b1;
            clk_en          <= 1'b0;
            sys_rst_n       <= 1'b0;
            lock_lost_count <= '0;
            retry_count     <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            // Lock from a PLL held in reset is meaningless: qualification starts fresh in WAIT.
            if (state_q == S_PLLRST)
                sync_q <= '0;
            else
                sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            pll_rst         <= (state_d == S_PLLRST);
            clk_en          <= (state_d == S_HOLD) || (state_d == S_RUN);
            sys_rst_n       <= (state_d == S_RUN);
            lock_lost_count <= cnt_next(lock_lost_count, lost_inc, clear_counts);
            retry_count     <= cnt_next(retry_count, retry_inc, clear_counts);
        end
    end

endmodule
